// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

  localparam int unsigned BYTES_PER_INSTR = 4;
  localparam int unsigned PC_STEP         = 4;
  localparam int unsigned CNT_W           = $clog2(BYTES_PER_INSTR);
  localparam int unsigned INSTR_W         = 8 * BYTES_PER_INSTR;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    VALID
  } fetch_state_e;

  typedef logic [CNT_W-1:0] byte_cnt_t;

endpackage

// File: rtl/instr_byte_assembler.sv
// Collects the bytes of one instruction into slots and presents them big-endian.
module instr_byte_assembler
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               wr_en,
  input  byte_cnt_t          slot,
  input  logic [7:0]         wdata,
  output logic [INSTR_W-1:0] word
);

  logic [7:0] slot_q [BYTES_PER_INSTR];

  // Clear wins over a write so a flushed fetch leaves nothing behind.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      for (int i = 0; i < int'(BYTES_PER_INSTR); i++) begin
        slot_q[i] <= '0;
      end
    end else if (wr_en) begin
      slot_q[slot] <= wdata;
    end
  end

  assign word = {slot_q[0], slot_q[1], slot_q[2], slot_q[3]};

endmodule

// File: rtl/fetch_sequencer.sv
// Byte-serial instruction fetch: owns the PC, reads four bytes, hands one word to decode.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W   = 10,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_en,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               mem_rd_en,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [7:0]         mem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [31:0]        instr_pc,
  output logic               busy
);

  localparam byte_cnt_t LAST_CNT = CNT_W'(BYTES_PER_INSTR - 1);

  fetch_state_e      state_q, state_d;
  logic [31:0]       pc_q, pc_d, instr_pc_d;
  byte_cnt_t         cnt_q, cnt_d, slot_q;
  logic              pending_q;
  logic              handshake;
  logic [ADDR_W-1:0] addr_d;
  logic              unused_redirect_lsb;

  assign handshake           = instr_valid & instr_ready;
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, PC and byte counter; redirect overrides everything else.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    instr_pc_d = instr_pc;
    unique case (state_q)
      IDLE: begin
        if (fetch_en) begin
          state_d = ISSUE;
          cnt_d   = '0;
        end
      end
      ISSUE: begin
        if (cnt_q == LAST_CNT) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DRAIN: begin
        state_d    = VALID;
        instr_pc_d = pc_q;
      end
      VALID: begin
        if (handshake) begin
          pc_d    = pc_q + 32'(PC_STEP);
          cnt_d   = '0;
          state_d = fetch_en ? ISSUE : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (redirect_valid) begin
      pc_d    = {redirect_pc[31:2], 2'b00};
      cnt_d   = '0;
      state_d = fetch_en ? ISSUE : IDLE;
    end
    addr_d = (state_d == ISSUE) ? pc_d[ADDR_W-1:0] + ADDR_W'(cnt_d) : '0;
  end

  // Datapath and registered outputs, decoded from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      cnt_q       <= '0;
      slot_q      <= '0;
      pending_q   <= 1'b0;
      mem_rd_en   <= 1'b0;
      mem_addr    <= '0;
      instr_valid <= 1'b0;
      instr_pc    <= '0;
      busy        <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      cnt_q       <= cnt_d;
      slot_q      <= cnt_q;
      pending_q   <= mem_rd_en & ~redirect_valid;
      mem_rd_en   <= (state_d == ISSUE);
      mem_addr    <= addr_d;
      instr_valid <= (state_d == VALID);
      instr_pc    <= instr_pc_d;
      busy        <= (state_d != IDLE);
    end
  end

  instr_byte_assembler u_asm (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (redirect_valid),
    .wr_en (pending_q),
    .slot  (slot_q),
    .wdata (mem_rdata),
    .word  (instr)
  );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer with a byte-memory model and PC scoreboard.
module tb_fetch_sequencer;

  localparam int unsigned ADDR_W    = 10;
  localparam int unsigned MEM_BYTES = 1 << ADDR_W;

  logic              clk;
  logic              rst_n;
  logic              fetch_en;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic              instr_valid;
  logic              instr_ready;
  logic [31:0]       instr;
  logic [31:0]       instr_pc;
  logic              busy;

  logic [7:0]        mem [MEM_BYTES];
  logic [ADDR_W-1:0] addr_log [$];
  int checks   = 0;
  int failures = 0;

  fetch_sequencer #(.ADDR_W(ADDR_W), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_rd_en      (mem_rd_en),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read byte store; junk on the bus whenever nothing was read.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
    else           mem_rdata <= 8'($urandom);
  end

  always @(posedge clk) begin
    if (rst_n && mem_rd_en) addr_log.push_back(mem_addr);
  end

  // Big-endian word at a byte address, wrapping around the store.
  function automatic logic [31:0] ref_word(input logic [31:0] pc);
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < 4; k++) begin
      w = {w[23:0], mem[int'((pc + 32'(k)) % 32'(MEM_BYTES))]};
    end
    return w;
  endfunction

  function automatic bit log_is(input int base);
    bit ok;
    ok = (addr_log.size() == 4);
    if (ok) begin
      for (int k = 0; k < 4; k++) begin
        if (addr_log[k] !== ADDR_W'((base + k) % int'(MEM_BYTES))) ok = 0;
      end
    end
    return ok;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      if (!ok) begin
        if (instr_valid === 1'b1) ok = 1;
        else step();
      end
    end
  endtask

  task automatic handshake_once();
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; fetch_en = 1'b0; redirect_valid = 1'b0;
    redirect_pc = '0; instr_ready = 1'b0;
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fetch_en = 1'b1; redirect_valid = 1'b0;
    redirect_pc = '0; instr_ready = 1'b0;
    step(); step();
    checks++;
    if ({instr_valid, mem_rd_en, busy} !== 3'b000) begin
      failures++;
      $display("FAIL reset_ctrl: got valid/rd/busy=%b expected 000", {instr_valid, mem_rd_en, busy});
    end
    checks++;
    if (instr !== 32'h0 || instr_pc !== 32'h0 || mem_addr !== '0) begin
      failures++;
      $display("FAIL reset_data: got instr=%h pc=%h addr=%h expected all 0", instr, instr_pc, mem_addr);
    end
    rst_n = 1'b1; fetch_en = 1'b0;
  endtask

  task automatic test_basic();
    apply_reset();
    mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h56; mem[3] = 8'h78;
    fetch_en = 1'b1;
    step();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (mem_rd_en !== 1'b1 || mem_addr !== ADDR_W'(k)) begin
        failures++;
        $display("FAIL basic_issue%0d: got rd=%b addr=%h expected rd=1 addr=%h", k, mem_rd_en, mem_addr, k);
      end
      step();
    end
    checks++;
    if (instr_valid !== 1'b0 || mem_rd_en !== 1'b0) begin
      failures++;
      $display("FAIL basic_drain: got valid=%b rd=%b expected 0 0", instr_valid, mem_rd_en);
    end
    step();
    checks++;
    if (instr_valid !== 1'b1 || instr !== 32'h12345678 || instr_pc !== 32'h0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL basic_valid: got v=%b instr=%h pc=%h busy=%b expected 1 12345678 0 1",
               instr_valid, instr, instr_pc, busy);
    end
  endtask

  task automatic test_stall();
    bit ok;
    instr_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (instr_valid !== 1'b1 || instr !== ref_word(0) || instr_pc !== 32'h0 || mem_rd_en !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold%0d: got v=%b instr=%h pc=%h rd=%b expected 1 %h 0 0",
                 i, instr_valid, instr, instr_pc, mem_rd_en, ref_word(0));
      end
    end
    addr_log.delete();
    handshake_once();
    wait_valid(ok);
    checks++;
    if (!ok || !log_is(4) || instr_pc !== 32'h4 || instr !== ref_word(4)) begin
      failures++;
      $display("FAIL stall_next: got ok=%b n=%0d pc=%h instr=%h expected addrs 4..7 pc=4 instr=%h",
               ok, addr_log.size(), instr_pc, instr, ref_word(4));
    end
  endtask

  task automatic test_redirect_mid();
    bit ok;
    apply_reset();
    mem[32'h102] = ~mem[2];
    fetch_en = 1'b1;
    step(); step(); step();
    checks++;
    if (mem_rd_en !== 1'b1 || mem_addr !== ADDR_W'(2)) begin
      failures++;
      $display("FAIL redir_mid_pos: got rd=%b addr=%h expected 1 002", mem_rd_en, mem_addr);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    step();
    redirect_valid = 1'b0;
    addr_log.delete();
    wait_valid(ok);
    checks++;
    if (!ok || !log_is(32'h100) || instr_pc !== 32'h100 || instr !== ref_word(32'h100)) begin
      failures++;
      $display("FAIL redir_mid: got ok=%b n=%0d pc=%h instr=%h expected addrs 100..103 pc=100 instr=%h",
               ok, addr_log.size(), instr_pc, instr, ref_word(32'h100));
    end
  endtask

  task automatic test_redirect_handshake();
    bit ok;
    apply_reset();
    fetch_en = 1'b1;
    wait_valid(ok); handshake_once();
    wait_valid(ok); handshake_once();
    wait_valid(ok);
    checks++;
    if (!ok || instr_pc !== 32'h8 || instr !== ref_word(32'h8)) begin
      failures++;
      $display("FAIL redir_hs_word: got ok=%b pc=%h instr=%h expected pc=8 instr=%h",
               ok, instr_pc, instr, ref_word(32'h8));
    end
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0040; instr_ready = 1'b1;
    step();
    redirect_valid = 1'b0; instr_ready = 1'b0;
    addr_log.delete();
    checks++;
    if (instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL redir_hs_drop: got valid=%b expected 0", instr_valid);
    end
    wait_valid(ok);
    checks++;
    if (!ok || !log_is(32'h40) || instr_pc !== 32'h40 || instr !== ref_word(32'h40)) begin
      failures++;
      $display("FAIL redir_hs_next: got ok=%b n=%0d pc=%h instr=%h expected addrs 40..43 pc=40",
               ok, addr_log.size(), instr_pc, instr);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_03FE;
    step();
    redirect_valid = 1'b0;
    addr_log.delete();
    wait_valid(ok);
    checks++;
    if (!ok || !log_is(32'h3FC) || instr_pc !== 32'h3FC) begin
      failures++;
      $display("FAIL wrap_align: got ok=%b n=%0d pc=%h expected addrs 3fc..3ff pc=3fc",
               ok, addr_log.size(), instr_pc);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h0000_03FC;
    step();
    redirect_valid = 1'b0;
    wait_valid(ok);
    handshake_once();
    addr_log.delete();
    wait_valid(ok);
    checks++;
    if (!ok || !log_is(0) || instr_pc !== 32'h400 || instr !== ref_word(32'h400)) begin
      failures++;
      $display("FAIL wrap_addr: got ok=%b n=%0d pc=%h instr=%h expected addrs 0..3 pc=400 instr=%h",
               ok, addr_log.size(), instr_pc, instr, ref_word(32'h400));
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    apply_reset();
    fetch_en = 1'b1;
    step(); step();
    checks++;
    if (mem_rd_en !== 1'b1 || mem_addr !== ADDR_W'(1)) begin
      failures++;
      $display("FAIL rst_mid_pos: got rd=%b addr=%h expected 1 001", mem_rd_en, mem_addr);
    end
    rst_n = 1'b0;
    step();
    checks++;
    if ({instr_valid, mem_rd_en, busy} !== 3'b000 || mem_addr !== '0 || instr !== 32'h0 || instr_pc !== 32'h0) begin
      failures++;
      $display("FAIL rst_mid_out: got v/rd/busy=%b addr=%h instr=%h pc=%h expected all 0",
               {instr_valid, mem_rd_en, busy}, mem_addr, instr, instr_pc);
    end
    rst_n = 1'b1;
    addr_log.delete();
    wait_valid(ok);
    checks++;
    if (!ok || !log_is(0) || instr_pc !== 32'h0 || instr !== ref_word(0)) begin
      failures++;
      $display("FAIL rst_mid_pc: got ok=%b n=%0d pc=%h instr=%h expected addrs 0..3 pc=0",
               ok, addr_log.size(), instr_pc, instr);
    end
  endtask

  task automatic test_fetch_en_drop();
    apply_reset();
    fetch_en = 1'b1;
    step();
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (mem_rd_en !== 1'b0 || busy !== 1'b1 || instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL drop_drain: got rd=%b busy=%b v=%b expected 0 1 0", mem_rd_en, busy, instr_valid);
    end
    fetch_en = 1'b0;
    step();
    checks++;
    if (instr_valid !== 1'b1 || instr !== ref_word(0)) begin
      failures++;
      $display("FAIL drop_valid: got v=%b instr=%h expected 1 %h", instr_valid, instr, ref_word(0));
    end
    handshake_once();
    step(); step();
    checks++;
    if (busy !== 1'b0 || instr_valid !== 1'b0 || mem_rd_en !== 1'b0) begin
      failures++;
      $display("FAIL drop_idle: got busy=%b v=%b rd=%b expected 0 0 0", busy, instr_valid, mem_rd_en);
    end
  endtask

  task automatic test_random();
    logic [31:0] pc_m, prev_instr;
    bit prev_valid, prev_event;
    int hs;
    apply_reset();
    for (int i = 0; i < int'(MEM_BYTES); i++) mem[i] = 8'($urandom);
    pc_m = 32'h0; hs = 0; prev_valid = 0; prev_event = 0; prev_instr = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      instr_ready    = ($urandom % 3) != 0;
      redirect_valid = ($urandom % 25) == 0;
      redirect_pc    = $urandom;
      fetch_en       = ($urandom % 16) != 0;
      if (prev_valid && !prev_event) begin
        checks++;
        if (instr_valid !== 1'b1 || instr !== prev_instr) begin
          failures++;
          $display("FAIL rand_hold@%0d: got v=%b instr=%h expected 1 %h", cyc, instr_valid, instr, prev_instr);
        end
      end
      if (instr_valid === 1'b1 && instr_ready) begin
        checks++;
        hs++;
        if (instr_pc !== pc_m || instr !== ref_word(pc_m)) begin
          failures++;
          $display("FAIL rand_word@%0d: got pc=%h instr=%h expected pc=%h instr=%h",
                   cyc, instr_pc, instr, pc_m, ref_word(pc_m));
        end
        pc_m = pc_m + 32'd4;
      end
      if (redirect_valid) pc_m = {redirect_pc[31:2], 2'b00};
      prev_valid = (instr_valid === 1'b1);
      prev_instr = instr;
      prev_event = (instr_valid === 1'b1 && instr_ready) || redirect_valid;
      step();
    end
    redirect_valid = 1'b0;
    checks++;
    if (hs < 100) begin
      failures++;
      $display("FAIL rand_progress: got %0d handshakes expected at least 100", hs);
    end
  endtask

  initial begin
    for (int i = 0; i < int'(MEM_BYTES); i++) mem[i] = 8'($urandom);
    test_reset();
    test_basic();
    test_stall();
    test_redirect_mid();
    test_redirect_handshake();
    test_wrap();
    test_reset_mid();
    test_fetch_en_drop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
